// File: rtl/sparse_pkg.sv
// Shared constants, types and states for the operand pair dispatcher.
// A packet carries one 4-element vector plus an 8-bit header: the kind bit
// selects an A row or a B column and the 2-bit index names the slot.
package sparse_pkg;

    localparam int DATA_W   = 32;
    localparam int N        = 4;
    localparam int PKT_W    = 8 + N * DATA_W;

    localparam int KIND_BIT = 135;
    localparam int IDX_HI   = 129;
    localparam int IDX_LO   = 128;

    localparam logic [1:0] LAST_IDX = 2'(N - 1);

    typedef logic [DATA_W-1:0] float_t;
    typedef float_t [N-1:0]    vec_t;

    typedef enum logic [1:0] {
        LOAD,
        DISPATCH,
        DONE
    } state_t;

endpackage

// File: rtl/nz_pick.sv
// Finds the next selected element position in a dot product.
// Given a per-element selection mask and a starting position, it returns the
// lowest selected position at or above the start, whether one exists, and
// whether that position is the final selected one of the cell.
module nz_pick
    import sparse_pkg::*;
(
    input  logic [N-1:0] sel_i,
    input  logic [1:0]   start_i,
    output logic [1:0]   next_o,
    output logic         found_o,
    output logic         last_o
);

    // Scan downward so the lowest qualifying position wins, then look for any
    // selected position beyond it to decide whether the cell closes here.
    always_comb begin
        next_o  = start_i;
        found_o = 1'b0;
        last_o  = 1'b1;
        for (int b = N - 1; b >= 0; b--) begin
            if (sel_i[b] && (2'(b) >= start_i)) begin
                next_o  = 2'(b);
                found_o = 1'b1;
            end
        end
        for (int b = 0; b < N; b++) begin
            if (sel_i[b] && (2'(b) > next_o)) begin
                last_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/operand_pair_dispatcher.sv
// Operand pair dispatcher: buffers one 4x4 operand set (four A rows, four B
// columns) and streams (a,b) pairs for every output cell to the FPU array
// over a valid/ready handshake, flagging the last pair of each dot product.
// Build option ZERO_SKIP_EN: when defined, pairs whose product is zero (either
// element +0 or -0) are skipped and a cell with no surviving pair emits a
// single zero beat; when undefined every element of every cell is issued.
module operand_pair_dispatcher
    import sparse_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [PKT_W-1:0]  wr_data,
    output logic              busy,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [1:0]        op_row,
    output logic [1:0]        op_col,
    output logic              op_last,
    output logic              done
);

    state_t         state_q, state_d;
    logic [2*N-1:0] mask_q, mask_d;
    logic [1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
    logic           valid_q, valid_d, last_q, last_d, done_q, done_d;
    float_t         opA_q, opA_d, opB_q, opB_d;

    vec_t           aMem_q [N];
    vec_t           bMem_q [N];

    logic           wrKind;
    logic [1:0]     wrIdx;
    logic [2:0]     wrSlot;
    logic           wrAccept;
    vec_t           wrVec;
    logic           unusedHdr;

    logic [1:0]     nI, nJ;
    logic [N-1:0]   curSel, nxtSel;
    logic [1:0]     curK, nxtK;
    logic           curFound, nxtFound, curLast, nxtLast;
    float_t         curA, curB, nxtA, nxtB;
    logic           curBeatLast, nxtBeatLast;

    assign wrKind    = wr_data[KIND_BIT];
    assign wrIdx     = wr_data[IDX_HI:IDX_LO];
    assign wrSlot    = {wrKind, wrIdx};
    assign wrVec     = wr_data[N*DATA_W-1:0];
    assign unusedHdr = ^wr_data[KIND_BIT-1:IDX_HI+1];

    // Once all eight slots are held the set is frozen, so the first beat is
    // built from the same data the rest of the stream will use.
    assign wrAccept  = (state_q == LOAD) && wr_en && (mask_q != '1);

    // Vector storage survives reset; only the slot mask says what is valid.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            if (wrKind) begin
                bMem_q[wrIdx] <= wrVec;
            end else begin
                aMem_q[wrIdx] <= wrVec;
            end
        end
    end

    // Coordinates of the cell that follows the current one in row-major order;
    // while loading, the stream always begins at cell (0,0).
    always_comb begin
        nI = i_q;
        nJ = j_q;
        if (state_q == LOAD) begin
            nI = 2'd0;
            nJ = 2'd0;
        end else if (j_q == LAST_IDX) begin
            nI = i_q + 2'd1;
            nJ = 2'd0;
        end else begin
            nJ = j_q + 2'd1;
        end
    end

`ifdef ZERO_SKIP_EN
    // A pair is kept only when both magnitudes are nonzero; the sign bit is
    // ignored so -0 is treated like +0.
    always_comb begin
        curSel = '0;
        nxtSel = '0;
        for (int k = 0; k < N; k++) begin
            curSel[k] = (aMem_q[i_q][k][DATA_W-2:0] != '0) &&
                        (bMem_q[j_q][k][DATA_W-2:0] != '0);
            nxtSel[k] = (aMem_q[nI][k][DATA_W-2:0] != '0) &&
                        (bMem_q[nJ][k][DATA_W-2:0] != '0);
        end
    end
`else
    assign curSel = '1;
    assign nxtSel = '1;
`endif

    nz_pick u_cur_pick (
        .sel_i   (curSel),
        .start_i (k_q + 2'd1),
        .next_o  (curK),
        .found_o (curFound),
        .last_o  (curLast)
    );

    nz_pick u_nxt_pick (
        .sel_i   (nxtSel),
        .start_i (2'd0),
        .next_o  (nxtK),
        .found_o (nxtFound),
        .last_o  (nxtLast)
    );

    // Candidate beats: the next element of the current cell, or the first
    // element of the next cell. A cell with nothing selected yields a single
    // zero pair that closes the accumulator.
    always_comb begin
        curA        = curFound ? aMem_q[i_q][curK] : '0;
        curB        = curFound ? bMem_q[j_q][curK] : '0;
        curBeatLast = curFound ? curLast : 1'b1;
        nxtA        = nxtFound ? aMem_q[nI][nxtK] : '0;
        nxtB        = nxtFound ? bMem_q[nJ][nxtK] : '0;
        nxtBeatLast = nxtFound ? nxtLast : 1'b1;
    end

    // Control: collect slots, then hold each beat until the FPU takes it and
    // load the following one on the same edge so there is no bubble.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        valid_d = valid_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (wrAccept) begin
                    mask_d = mask_q | ((2*N)'(1) << wrSlot);
                end
                if (mask_q == '1) begin
                    state_d = DISPATCH;
                    i_d     = nI;
                    j_d     = nJ;
                    k_d     = nxtK;
                    valid_d = 1'b1;
                    opA_d   = nxtA;
                    opB_d   = nxtB;
                    last_d  = nxtBeatLast;
                end
            end
            DISPATCH: begin
                if (valid_q && op_ready) begin
                    if (!last_q) begin
                        k_d    = curK;
                        opA_d  = curA;
                        opB_d  = curB;
                        last_d = curBeatLast;
                    end else if ((i_q == LAST_IDX) && (j_q == LAST_IDX)) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        i_d     = 2'd0;
                        j_d     = 2'd0;
                        k_d     = 2'd0;
                        opA_d   = '0;
                        opB_d   = '0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        i_d    = nI;
                        j_d    = nJ;
                        k_d    = nxtK;
                        opA_d  = nxtA;
                        opB_d  = nxtB;
                        last_d = nxtBeatLast;
                    end
                end
            end
            DONE: begin
                state_d = LOAD;
                mask_d  = '0;
            end
            default: begin
                state_d = LOAD;
                mask_d  = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any set in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
            mask_q  <= '0;
            i_q     <= 2'd0;
            j_q     <= 2'd0;
            k_q     <= 2'd0;
            valid_q <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != LOAD);
    assign op_valid = valid_q;
    assign op_a     = opA_q;
    assign op_b     = opB_q;
    assign op_row   = i_q;
    assign op_col   = j_q;
    assign op_last  = last_q;
    assign done     = done_q;

endmodule

// File: tb/tb_operand_pair_dispatcher.sv
// Self-checking bench for operand_pair_dispatcher. A reference model of the
// pair-selection rules fills a scoreboard queue each time a set is loaded;
// beats are popped and compared as the handshake consumes them.
// Honours ZERO_SKIP_EN the same way the design does.
`timescale 1ns/1ps
module tb_operand_pair_dispatcher;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [135:0] wr_data;
    logic         busy;
    logic         op_valid;
    logic         op_ready;
    logic [31:0]  op_a;
    logic [31:0]  op_b;
    logic [1:0]   op_row;
    logic [1:0]   op_col;
    logic         op_last;
    logic         done;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  r;
        logic [1:0]  c;
        logic        last;
    } beat_t;

    localparam logic [31:0] ONE = 32'h3F80_0000;

    beat_t       sb[$];
    logic [31:0] mA [4][4];
    logic [31:0] mB [4][4];
    int          checks = 0;
    int          errors = 0;

    operand_pair_dispatcher dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .busy     (busy),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_row   (op_row),
        .op_col   (op_col),
        .op_last  (op_last),
        .done     (done)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Expected beat list for the current model contents
    function automatic int buildExpected();
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                logic [3:0] sel;
                int         lastK;
                sel   = '0;
                lastK = -1;
                for (int k = 0; k < 4; k++) begin
`ifdef ZERO_SKIP_EN
                    sel[k] = (mA[i][k][30:0] != 31'd0) && (mB[j][k][30:0] != 31'd0);
`else
                    sel[k] = 1'b1;
`endif
                    if (sel[k]) lastK = k;
                end
                if (lastK < 0) begin
                    sb.push_back('{a: 32'd0, b: 32'd0, r: 2'(i), c: 2'(j), last: 1'b1});
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        if (sel[k]) begin
                            sb.push_back('{a: mA[i][k], b: mB[j][k], r: 2'(i), c: 2'(j),
                                           last: (k == lastK)});
                        end
                    end
                end
            end
        end
        return sb.size();
    endfunction

    // One packet write lasting a single clock
    task automatic applyStimulus(input logic kind, input logic [1:0] idx, input logic [127:0] vec);
        wr_data = {kind, 5'b0, idx, vec};
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic writeSlot(input logic kind, input logic [1:0] idx);
        if (kind) applyStimulus(1'b1, idx, {mB[idx][3], mB[idx][2], mB[idx][1], mB[idx][0]});
        else      applyStimulus(1'b0, idx, {mA[idx][3], mA[idx][2], mA[idx][1], mA[idx][0]});
    endtask

    // A0..A3, B0..B2 and optionally B3
    task automatic loadVectors(input bit withLastSlot);
        for (int x = 0; x < 4; x++) writeSlot(1'b0, 2'(x));
        for (int x = 0; x < 3; x++) writeSlot(1'b1, 2'(x));
        if (withLastSlot) writeSlot(1'b1, 2'd3);
    endtask

    // Called right after the write that completes the set
    task automatic checkStart();
        checks++;
        if (op_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_gap: op_valid=%b busy=%b, wanted 0 0", op_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (op_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_latency: op_valid=%b busy=%b, wanted 1 1", op_valid, busy);
        end
    endtask

    // Consume beats against the scoreboard; readyMode 1 drives 1,0,0,1 on op_ready
    task automatic drain(input int readyMode, input int stopAfter, input bit inject, output int beats);
        bit    finalSeen = 1'b0;
        bit    finished  = 1'b0;
        beat_t expBeat;
        beats = 0;
        for (int c = 0; c < 2000 && !finished; c++) begin
            if (finalSeen) begin
                checks++;
                if (done !== 1'b1 || op_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL done_pulse: done=%b op_valid=%b, wanted 1 0", done, op_valid);
                end
                finished = 1'b1;
            end else begin
                if (inject) begin
                    if (c >= 3 && c < 11) begin
                        wr_data = {((c - 3) >= 4), 5'b0, 2'(c - 3), {4{32'hDEAD_BEEF}}};
                        wr_en   = 1'b1;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                op_ready = (readyMode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
                if (done === 1'b1) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL early_done: done=1 with %0d beats still expected", sb.size());
                end
                if (op_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL extra_beat: row=%0d col=%0d a=%h", op_row, op_col, op_a);
                        finished = 1'b1;
                    end else begin
                        expBeat = sb[0];
                        checks++;
                        if ({op_a, op_b, op_row, op_col, op_last, busy} !==
                            {expBeat.a, expBeat.b, expBeat.r, expBeat.c, expBeat.last, 1'b1}) begin
                            errors++;
                            $display("[TB] FAIL beat%0d: got a=%h b=%h r=%0d c=%0d last=%b busy=%b, wanted a=%h b=%h r=%0d c=%0d last=%b busy=1",
                                     beats, op_a, op_b, op_row, op_col, op_last, busy,
                                     expBeat.a, expBeat.b, expBeat.r, expBeat.c, expBeat.last);
                        end
                        if (op_ready) begin
                            void'(sb.pop_front());
                            beats++;
                            if (sb.size() == 0) finalSeen = 1'b1;
                            if (stopAfter != 0 && beats == stopAfter) finished = 1'b1;
                        end
                    end
                end
                if (!finished) @(negedge clk);
            end
        end
        wr_en = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d beats seen, %0d still expected", beats, sb.size());
        end
    endtask

    // Load the model set, stream it out and confirm the beat count and return to LOAD
    task automatic runSet(input string name, input int readyMode, input bit inject, input int wantBeats);
        int beats;
        void'(buildExpected());
        loadVectors(1'b1);
        checkStart();
        drain(readyMode, 0, inject, beats);
        checks++;
        if (beats !== wantBeats) begin
            errors++;
            $display("[TB] FAIL %s_count: got %0d beats, wanted %0d", name, beats, wantBeats);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || op_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle: busy=%b op_valid=%b done=%b, wanted 0 0 0", name, busy, op_valid, done);
        end
    endtask

    task automatic fillModel(input logic [31:0] aVal, input logic [31:0] bVal);
        for (int x = 0; x < 4; x++) begin
            for (int k = 0; k < 4; k++) begin
                mA[x][k] = aVal;
                mB[x][k] = bVal;
            end
        end
    endtask

    function automatic logic [31:0] randElem();
        if ($urandom_range(0, 2) == 0) return ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0;
        return $urandom;
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        op_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, op_valid, op_a, op_b, op_row, op_col, op_last, done} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: busy=%b valid=%b a=%h b=%h row=%0d col=%0d last=%b done=%b, wanted all 0",
                     busy, op_valid, op_a, op_b, op_row, op_col, op_last, done);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dense();
        fillModel(ONE, ONE);
        runSet("dense", 0, 1'b0, 64);
    endtask

    task automatic test_sparse_row();
        fillModel(ONE, ONE);
        mA[0][0] = 32'h0;
        mA[0][1] = 32'h4000_0000;
        mA[0][2] = 32'h0;
        mA[0][3] = 32'h8000_0000;
`ifdef ZERO_SKIP_EN
        runSet("sparse_row", 0, 1'b0, 52);
`else
        runSet("sparse_row", 0, 1'b0, 64);
`endif
    endtask

    task automatic test_all_zero_a();
        fillModel(32'h0, ONE);
        mA[1][2] = 32'h8000_0000;
        mA[3][0] = 32'h8000_0000;
`ifdef ZERO_SKIP_EN
        runSet("zero_a", 0, 1'b0, 16);
`else
        runSet("zero_a", 0, 1'b0, 64);
`endif
    endtask

    task automatic test_stall();
        fillModel(ONE, ONE);
        runSet("stall", 1, 1'b0, 64);
    endtask

    task automatic test_write_during_dispatch();
        int beats;
        int want;
        fillModel(ONE, ONE);
        runSet("wr_dispatch", 0, 1'b1, 64);
        for (int x = 0; x < 4; x++) begin
            for (int k = 0; k < 4; k++) begin
                mA[x][k] = randElem();
                mB[x][k] = randElem();
            end
        end
        want = buildExpected();
        applyStimulus(1'b0, 2'd0, {4{32'h1234_5678}});
        loadVectors(1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (op_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL partial_load: op_valid=%b busy=%b after 7 distinct slots, wanted 0 0", op_valid, busy);
        end
        writeSlot(1'b1, 2'd3);
        checkStart();
        drain(0, 0, 1'b0, beats);
        checks++;
        if (beats !== want) begin
            errors++;
            $display("[TB] FAIL random_count: got %0d beats, wanted %0d", beats, want);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int beats;
        fillModel(ONE, ONE);
        void'(buildExpected());
        loadVectors(1'b1);
        checkStart();
        drain(0, 10, 1'b0, beats);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, op_valid, op_a, op_b, op_row, op_col, op_last, done} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid: busy=%b valid=%b a=%h b=%h row=%0d col=%0d last=%b done=%b, wanted all 0",
                     busy, op_valid, op_a, op_b, op_row, op_col, op_last, done);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fillModel(32'h4040_0000, ONE);
        void'(buildExpected());
        loadVectors(1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (op_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mask: op_valid=%b busy=%b after 7 slots, wanted 0 0", op_valid, busy);
        end
        writeSlot(1'b1, 2'd3);
        checkStart();
        drain(0, 0, 1'b0, beats);
        checks++;
        if (beats !== 64) begin
            errors++;
            $display("[TB] FAIL reload_count: got %0d beats, wanted 64", beats);
        end
        @(negedge clk);
    endtask

    // Scenario sequence
    initial begin
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        op_ready = 1'b0;
        test_reset();
        test_dense();
        test_sparse_row();
        test_all_zero_a();
        test_stall();
        test_write_during_dispatch();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
